sar_result_collector: RTL and testbench
=======================================

# sar_result_collector

Digital back-end stage for the 2-bit SAR-ADC. It sits directly downstream of the SAR successive-approximation logic, runs on the same clock, and tracks the SAR's fixed 3-cycle conversion frame. At the end of each frame it captures the final 2-bit code, optionally accumulates 2^AVG_LOG2 consecutive codes, and presents the result to the consumer over a valid/ready handshake, with sticky overrun reporting.

## Interface
- AVG_LOG2, default 2: log2 of the number of conversions summed per result; 0 passes single codes through.
- OUT_W, default 2+AVG_LOG2: result width. This is derived, and must not be overridden.
- clk  input  1  system clock, same clock as the SAR logic (3x the sampler rate)
- rst  input  1  reset, synchronous, active-low; shares the net that resets the SAR logic
- en  input  1  accumulation enable; when low, captured codes are discarded
- sar_out1  input  1  SAR MSB output
- sar_out0  input  1  SAR LSB output
- res_data  output  OUT_W  sum of the last 2^AVG_LOG2 captured codes
- res_valid  output  1  res_data holds an unconsumed result
- res_ready  input  1  consumer accepts the result
- overrun  output  1  sticky flag: a completed result was dropped
- ovr_clr  input  1  clears overrun
- frame_phase  output  2  current frame phase (0,1,2), for debug and bench alignment

## Operation
- Frame tracking: a mod-3 phase counter runs 0→1→2→0 every cycle. On the first cycle after rst releases, phase=0, and this matches the SAR trial code 2'b10. At phase 1 the SAR shows {b1,1}. At phase 2 the SAR shows the final {b1,b0} and its internal done flag is set.
- Capture: when phase==2 and en=1, code={sar_out1,sar_out0} is added to the accumulator (width OUT_W), and the sample counter (width AVG_LOG2) increments. When en=0, phase still advances but nothing is captured.
- Result completion: the capture that makes sample count reach 2^AVG_LOG2 is the completing capture.
  - The completing value is acc+code.
  - After completion, the accumulator and sample count return to 0.
  - Maximum sum is 3·2^AVG_LOG2, which fits OUT_W with no saturation needed.
- Output register and handshake:
  - If res_valid=0 or res_ready=1 in the completion cycle, res_data is loaded with the completing value and res_valid is set.
  - Otherwise the new result is dropped, res_data and res_valid hold, and overrun sets.
  - Transfer occurs when res_valid and res_ready are both 1. If no load happens in the same cycle, res_valid clears.
  - While res_valid=1, res_data is stable.
- overrun stays set until ovr_clr=1. If ovr_clr and a new drop occur in the same cycle, overrun stays 1, because set wins.
- en falling mid-average: the partial accumulation is kept and resumes when en returns high. It is never flushed.
- Codes observed at phases 0 and 1 are never used.

## Timing
- Reset (rst=0 at a clk edge) drives: phase=0, accumulator=0, sample count=0, res_data=0, res_valid=0, overrun=0, frame_phase=0.
- Reset mid-frame or mid-average aborts the frame and discards the partial sum. A pending result is lost.
- Capture latency: with the final code present at phase 2 in cycle N, res_valid rises at cycle N+1, provided the output register is free or being consumed.
- Result period is 3·2^AVG_LOG2 cycles with en held high. The first result is valid 3·2^AVG_LOG2 cycles after rst release.
- res_ready is sampled on clk. Back-to-back consume-and-load in the same cycle keeps res_valid=1 with no bubble.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package sar_pkg holds the shared constants and types:
  - CODE_W=2, FRAME_LEN=3, and the phase encoding PH_TRIAL=0, PH_MSB=1, PH_FINAL=2.
  - SAR_RESET_CODE=2'b10.
  - Shared with the SAR logic and the bench.
- Sub-module sar_frame_counter contains the mod-3 phase counter with synchronous active-low reset. It outputs phase and a final_strobe pulse at PH_FINAL. The bench reuses it as a reference frame model.
- The top level holds the accumulator, sample counter, output register and overrun logic.

## Test plan
- Pass-through (AVG_LOG2=0): the SAR resolves codes 3,0,2,1 in successive frames with res_ready=1. Required: res_valid is high for 1 cycle per frame with res_data=3,0,2,1, each 1 cycle after phase 2.
- Averaging (AVG_LOG2=2): four codes 3,3,3,3 with res_ready=1. Required: res_data=12 (max, no wrap), then codes 1,0,2,1 give res_data=4. Results arrive 12 cycles apart.
- Backpressure: AVG_LOG2=0 with res_ready=0 for 2 frames, codes 2 then 1. Required: res_data stays 2, overrun=1 after the second frame. Then ovr_clr=1 gives overrun=0, and res_ready=1 gives one transfer of 2.
- en gating: AVG_LOG2=1, en=1 for the code-3 frame, en=0 for 2 frames, en=1 for the code-1 frame. Required: exactly one result, res_data=4.
- Reset mid-average: AVG_LOG2=2, capture 2 codes, then assert rst for 1 cycle. Required: all outputs are 0 next cycle, frame_phase restarts at 0, and the next result sums only post-reset codes.
- Simultaneous consume-and-load: res_valid=1, res_ready=1 in a completion cycle. Required: res_valid stays 1, res_data updates to the new value, and overrun stays 0.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared constants and types for the 2-bit SAR-ADC datapath: code width, frame
// length, phase encoding and the trial code the SAR presents at the start of a frame.
package sar_pkg;

   localparam int CODE_W    = 2;
   localparam int FRAME_LEN = 3;

   typedef enum logic [1:0] {
      PH_TRIAL = 2'd0,
      PH_MSB   = 2'd1,
      PH_FINAL = 2'd2
   } phase_t;

   localparam logic [CODE_W-1:0] SAR_RESET_CODE = 2'b10;

endpackage

// File: rtl/sar_frame_counter.sv
// Mod-3 frame phase counter that follows the SAR conversion frame; final_strobe
// is registered so that it is high exactly while phase sits at PH_FINAL.
module sar_frame_counter
   import sar_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   output logic [1:0] phase,
   output logic       final_strobe
);

   phase_t ph;

   assign phase = ph;

   // Strobe is loaded one cycle ahead so it coincides with the PH_FINAL cycle
   always_ff @(posedge clk) begin
      if (!rst) begin
         ph           <= PH_TRIAL;
         final_strobe <= 1'b0;
      end else begin
         case (ph)
            PH_TRIAL: ph <= PH_MSB;
            PH_MSB:   ph <= PH_FINAL;
            default:  ph <= PH_TRIAL;
         endcase
         final_strobe <= (ph == PH_MSB);
      end
   end

endmodule

// File: rtl/sar_result_collector.sv
// Captures the final SAR code of each frame, sums 2^AVG_LOG2 of them and offers
// the sum over valid/ready, flagging results dropped under backpressure.
module sar_result_collector
   import sar_pkg::*;
#(
   parameter int AVG_LOG2 = 2,
   parameter int OUT_W    = 2 + AVG_LOG2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sar_out1,
   input  logic             sar_out0,
   output logic [OUT_W-1:0] res_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             overrun,
   input  logic             ovr_clr,
   output logic [1:0]       frame_phase
);

   // A zero-width counter is not legal, so pass-through keeps one idle bit
   localparam int               CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

   logic [1:0]        phase;
   logic              final_strobe;
   logic [CODE_W-1:0] code;
   logic [OUT_W-1:0]  acc;
   logic [OUT_W-1:0]  sum;
   logic [CNT_W-1:0]  cnt;
   logic              capture;
   logic              complete;
   logic              load;
   logic              drop;

   sar_frame_counter u_frame (
      .clk          (clk),
      .rst          (rst),
      .phase        (phase),
      .final_strobe (final_strobe)
   );

   assign frame_phase = phase;
   assign code        = {sar_out1, sar_out0};
   assign sum         = acc + OUT_W'(code);
   assign capture     = final_strobe & en;
   assign complete    = capture & (cnt == LAST_CNT);
   assign load        = complete & (~res_valid | res_ready);
   assign drop        = complete & res_valid & ~res_ready;

   // Accumulator and sample count; a partial sum survives en going low
   always_ff @(posedge clk) begin
      if (!rst) begin
         acc <= '0;
         cnt <= '0;
      end else if (capture) begin
         if (complete) begin
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= sum;
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Output register: a load during a transfer keeps valid high with no bubble
   always_ff @(posedge clk) begin
      if (!rst) begin
         res_data  <= '0;
         res_valid <= 1'b0;
      end else if (load) begin
         res_data  <= sum;
         res_valid <= 1'b1;
      end else if (res_valid && res_ready) begin
         res_valid <= 1'b0;
      end
   end

   // Sticky overrun, where a fresh drop outranks a clear in the same cycle
   always_ff @(posedge clk) begin
      if (!rst) begin
         overrun <= 1'b0;
      end else if (drop) begin
         overrun <= 1'b1;
      end else if (ovr_clr) begin
         overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sar_result_collector.sv
// Bench for sar_result_collector: three instances (AVG_LOG2 = 0, 1, 2) share one
// stimulus stream and are compared against vector tables and a frame-level model.
module tb_sar_result_collector;
   import sar_pkg::*;

   logic       clk;
   logic       rst;
   logic       en;
   logic       sar1;
   logic       sar0;
   logic       res_ready;
   logic       ovr_clr;

   logic [1:0] d0_data;
   logic [2:0] d1_data;
   logic [3:0] d2_data;
   logic       d0_valid, d1_valid, d2_valid;
   logic       d0_ovr, d1_ovr, d2_ovr;
   logic [1:0] d0_phase, d1_phase, d2_phase;
   logic [1:0] ref_phase;
   logic       ref_strobe;

   int         n_assert;
   int         n_fail;
   logic [1:0] tgt;

   // Frame-level reference state, one slot per AVG_LOG2 value
   int         mphase;
   int         msum[3];
   int         mcnt[3];
   int         mdata[3];
   bit         mval[3];
   bit         movr[3];

   typedef struct {
      bit         rst_first;
      int         sel;
      logic [1:0] code;
      bit         en;
      bit         rdy;
      bit         clr;
      bit         exp_valid;
      int         exp_data;
      bit         exp_ovr;
   } vec_t;

   vec_t vq[$];

   sar_result_collector #(.AVG_LOG2(0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .sar_out1(sar1), .sar_out0(sar0),
      .res_data(d0_data), .res_valid(d0_valid), .res_ready(res_ready),
      .overrun(d0_ovr), .ovr_clr(ovr_clr), .frame_phase(d0_phase)
   );

   sar_result_collector #(.AVG_LOG2(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .sar_out1(sar1), .sar_out0(sar0),
      .res_data(d1_data), .res_valid(d1_valid), .res_ready(res_ready),
      .overrun(d1_ovr), .ovr_clr(ovr_clr), .frame_phase(d1_phase)
   );

   sar_result_collector #(.AVG_LOG2(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .sar_out1(sar1), .sar_out0(sar0),
      .res_data(d2_data), .res_valid(d2_valid), .res_ready(res_ready),
      .overrun(d2_ovr), .ovr_clr(ovr_clr), .frame_phase(d2_phase)
   );

   sar_frame_counter ref_frame (
      .clk(clk), .rst(rst), .phase(ref_phase), .final_strobe(ref_strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic int dut_valid(input int s);
      case (s)
         0:       return int'(d0_valid);
         1:       return int'(d1_valid);
         default: return int'(d2_valid);
      endcase
   endfunction

   function automatic int dut_data(input int s);
      case (s)
         0:       return int'(d0_data);
         1:       return int'(d1_data);
         default: return int'(d2_data);
      endcase
   endfunction

   function automatic int dut_ovr(input int s);
      case (s)
         0:       return int'(d0_ovr);
         1:       return int'(d1_ovr);
         default: return int'(d2_ovr);
      endcase
   endfunction

   // Advance the reference by one clock using the inputs currently applied
   task automatic model_step();
      int  code;
      bit  done;
      int  val;
      bit  dropped;
      code = int'({sar1, sar0});
      if (!rst) begin
         mphase = 0;
         for (int k = 0; k < 3; k++) begin
            msum[k] = 0; mcnt[k] = 0; mdata[k] = 0; mval[k] = 0; movr[k] = 0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            done    = 0;
            val     = 0;
            dropped = 0;
            if (mphase == 2 && en) begin
               msum[k] += code;
               mcnt[k] += 1;
               if (mcnt[k] == (1 << k)) begin
                  done    = 1;
                  val     = msum[k];
                  msum[k] = 0;
                  mcnt[k] = 0;
               end
            end
            if (done) begin
               if (!mval[k] || res_ready) begin
                  mdata[k] = val;
                  mval[k]  = 1;
               end else begin
                  dropped = 1;
                  movr[k] = 1;
               end
            end else if (mval[k] && res_ready) begin
               mval[k] = 0;
            end
            if (!dropped && ovr_clr) movr[k] = 0;
         end
         mphase = (mphase + 1) % 3;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("frame_phase d0", int'(d0_phase), mphase);
      chk("frame_phase d1", int'(d1_phase), mphase);
      chk("frame_phase d2", int'(d2_phase), mphase);
      chk("ref final_strobe", int'(ref_strobe), int'(mphase == 2));
   endtask

   task automatic set_sar();
      case (mphase)
         0:       {sar1, sar0} = SAR_RESET_CODE;
         1:       {sar1, sar0} = {tgt[1], 1'b1};
         default: {sar1, sar0} = tgt;
      endcase
   endtask

   task automatic do_reset();
      rst = 1'b0;
      set_sar();
      tick();
      rst = 1'b1;
   endtask

   task automatic applyStimulus(input logic [1:0] c, input bit e, input bit r, input bit cl);
      tgt       = c;
      en        = e;
      res_ready = r;
      ovr_clr   = cl;
      repeat (3) begin
         set_sar();
         tick();
      end
   endtask

   task automatic checkOutput(input string nm, input int s, input int ev, input int ed, input int eo);
      chk({nm, " valid"},   dut_valid(s), ev);
      chk({nm, " data"},    dut_data(s),  ed);
      chk({nm, " overrun"}, dut_ovr(s),   eo);
   endtask

   task automatic add(input bit r, input int s, input logic [1:0] c, input bit e,
                      input bit rd, input bit cl, input bit ev, input int ed, input bit eo);
      vec_t v;
      v.rst_first = r; v.sel = s; v.code = c; v.en = e; v.rdy = rd; v.clr = cl;
      v.exp_valid = ev; v.exp_data = ed; v.exp_ovr = eo;
      vq.push_back(v);
   endtask

   task automatic check_all_model(input string nm);
      for (int k = 0; k < 3; k++) checkOutput($sformatf("%s d%0d", nm, k), k, int'(mval[k]), mdata[k], int'(movr[k]));
   endtask

   initial begin
      int first0, first2, second2;
      bit prev0, prev2;

      n_assert = 0; n_fail = 0;
      rst = 1'b0; en = 1'b0; res_ready = 1'b0; ovr_clr = 1'b0; tgt = 2'd0;
      {sar1, sar0} = SAR_RESET_CODE;
      mphase = 0;
      for (int k = 0; k < 3; k++) begin
         msum[k] = 0; mcnt[k] = 0; mdata[k] = 0; mval[k] = 0; movr[k] = 0;
      end

      $display("[TB] reset state");
      do_reset();
      for (int k = 0; k < 3; k++) checkOutput($sformatf("reset d%0d", k), k, 0, 0, 0);

      // Pass-through and backpressure on AVG_LOG2=0
      add(1, 0, 2'd3, 1, 1, 0, 1, 3, 0);
      add(0, 0, 2'd0, 1, 1, 0, 1, 0, 0);
      add(0, 0, 2'd2, 1, 1, 0, 1, 2, 0);
      add(0, 0, 2'd1, 1, 1, 0, 1, 1, 0);
      add(0, 0, 2'd3, 0, 1, 0, 0, 1, 0);
      add(0, 0, 2'd2, 1, 0, 0, 1, 2, 0);
      add(0, 0, 2'd1, 1, 0, 0, 1, 2, 1);
      add(0, 0, 2'd0, 0, 0, 1, 1, 2, 0);
      add(0, 0, 2'd0, 0, 1, 0, 0, 2, 0);
      add(0, 0, 2'd0, 0, 1, 0, 0, 2, 0);
      // Averaging of four on AVG_LOG2=2
      add(1, 2, 2'd3, 1, 1, 0, 0, 0, 0);
      add(0, 2, 2'd3, 1, 1, 0, 0, 0, 0);
      add(0, 2, 2'd3, 1, 1, 0, 0, 0, 0);
      add(0, 2, 2'd3, 1, 1, 0, 1, 12, 0);
      add(0, 2, 2'd1, 1, 1, 0, 0, 12, 0);
      add(0, 2, 2'd0, 1, 1, 0, 0, 12, 0);
      add(0, 2, 2'd2, 1, 1, 0, 0, 12, 0);
      add(0, 2, 2'd1, 1, 1, 0, 1, 4, 0);
      // en gating on AVG_LOG2=1
      add(1, 1, 2'd3, 1, 1, 0, 0, 0, 0);
      add(0, 1, 2'd2, 0, 1, 0, 0, 0, 0);
      add(0, 1, 2'd3, 0, 1, 0, 0, 0, 0);
      add(0, 1, 2'd1, 1, 1, 0, 1, 4, 0);
      add(0, 1, 2'd2, 0, 1, 0, 0, 4, 0);
      add(0, 1, 2'd3, 0, 1, 0, 0, 4, 0);

      $display("[TB] vector table, %0d frames", vq.size());
      foreach (vq[i]) begin
         if (vq[i].rst_first) do_reset();
         applyStimulus(vq[i].code, vq[i].en, vq[i].rdy, vq[i].clr);
         checkOutput($sformatf("vec%0d", i), vq[i].sel, int'(vq[i].exp_valid), vq[i].exp_data, int'(vq[i].exp_ovr));
      end

      $display("[TB] reset mid-average");
      do_reset();
      applyStimulus(2'd3, 1, 1, 0);
      applyStimulus(2'd3, 1, 1, 0);
      do_reset();
      for (int k = 0; k < 3; k++) checkOutput($sformatf("midreset d%0d", k), k, 0, 0, 0);
      chk("midreset phase", int'(d2_phase), 0);
      repeat (4) applyStimulus(2'd1, 1, 0, 0);
      checkOutput("post-reset sum", 2, 1, 4, 0);

      $display("[TB] consume-and-load");
      do_reset();
      applyStimulus(2'd2, 1, 0, 0);
      checkOutput("cl first", 0, 1, 2, 0);
      tgt = 2'd1; en = 1'b1; res_ready = 1'b0; ovr_clr = 1'b0;
      set_sar(); tick();
      set_sar(); tick();
      res_ready = 1'b1;
      set_sar(); tick();
      checkOutput("cl load", 0, 1, 1, 0);

      $display("[TB] result latency and period");
      do_reset();
      en = 1'b1; res_ready = 1'b1; ovr_clr = 1'b0;
      first0 = -1; first2 = -1; second2 = -1;
      prev0 = 1'b0; prev2 = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (mphase == 0) tgt = 2'($urandom_range(0, 3));
         set_sar();
         tick();
         if (d0_valid && !prev0 && first0 < 0) first0 = cyc;
         if (d2_valid && !prev2) begin
            if (first2 < 0) first2 = cyc;
            else if (second2 < 0) second2 = cyc;
         end
         prev0 = d0_valid;
         prev2 = d2_valid;
      end
      chk("first result d0 cycle", first0, 3);
      chk("first result d2 cycle", first2, 12);
      chk("result period d2", second2 - first2, 12);

      $display("[TB] randomized run against model");
      do_reset();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if ($urandom_range(0, 99) == 0) rst = 1'b0;
         if (mphase == 0) tgt = 2'($urandom_range(0, 3));
         en        = ($urandom_range(0, 7) != 0);
         res_ready = ($urandom_range(0, 2) != 0);
         ovr_clr   = ($urandom_range(0, 9) == 0);
         set_sar();
         tick();
         rst = 1'b1;
         check_all_model("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
